fmul_share_arb: RTL and testbench

Arbiter and sequencer that shares one pipelined FP32 multiplier among `N_REQ` requesters in the GRU equalizer datapath. The shared multiplier is the pre-normalise, mantissa multiply and `post_norm_mul1` chain. Each cycle the block grants one requester and launches its operand pair into the multiplier. It tracks a requester-ID tag alongside each in-flight operation and returns the result to the issuing requester. When the response side backpressures, it stalls the whole multiplier pipeline.

---
 rtl/fmul_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/fmul_share_arb.sv | 116 +++++++++++
 tb/tb_fmul_share_arb.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_arb_pkg.sv
// Shared types for the FP32 multiplier share arbiter.
// Tag bundle, operand/rounding types, default latency.
package fmul_arb_pkg;

  typedef logic [31:0] fp32_t;
  typedef logic [1:0]  rmode_t;

  localparam rmode_t RM_RNE = 2'b00;
  localparam rmode_t RM_RTZ = 2'b01;
  localparam rmode_t RM_RUP = 2'b10;
  localparam rmode_t RM_RDN = 2'b11;

  localparam int FMUL_LAT_DEFAULT = 3;

  // wide enough for the largest requester count (8)
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant picker, round-robin from ptr by default.
// FMUL_ARB_FIXED_PRIO_EN selects lowest-index-wins priority.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

`ifdef FMUL_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = |ptr;

  // first requester from index 0 upward wins
  always_comb begin
    logic found;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = W'(i);
      end
    end
  end
`else
  // first requester at or after ptr, wrapping, wins
  always_comb begin
    logic         found;
    logic [W-1:0] k;
    found = 1'b0;
    k     = '0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      k = W'((int'(ptr) + i) % N);
      if (en && !found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end
`endif

endmodule

// File: rtl/fmul_share_arb.sv
// Shares one pipelined FP32 multiplier among N_REQ requesters.
// Macro FMUL_ARB_FIXED_PRIO_EN: fixed priority, no rr pointer.
module fmul_share_arb
  import fmul_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = FMUL_LAT_DEFAULT,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_REQ-1:0]  req_valid_i,
  input  logic [N_REQ*32-1:0] req_opa_i,
  input  logic [N_REQ*32-1:0] req_opb_i,
  output logic [N_REQ-1:0]  req_ready_o,
  input  rmode_t            rmode_i,
  output logic              mul_en_o,
  output fp32_t             mul_opa_o,
  output fp32_t             mul_opb_o,
  output rmode_t            mul_rmode_o,
  input  fp32_t             mul_result_i,
  output logic              rsp_valid_o,
  output logic [ID_W-1:0]   rsp_id_o,
  output fp32_t             rsp_data_o,
  input  logic              rsp_ready_i,
  output logic              busy_o
);

  tag_t                tags [MUL_LAT];
  logic [N_REQ-1:0]    gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W-1:0]     arb_ptr;
  logic                xfer;
  logic                rsp_valid;
  logic [TAG_ID_W-1:0] unused_id;

  assign rsp_valid   = tags[MUL_LAT-1].valid;
  assign mul_en_o    = !(rsp_valid && !rsp_ready_i);
  assign xfer        = |gnt;
  assign req_ready_o = gnt;

  assign rsp_valid_o = rsp_valid;
  assign rsp_id_o    = tags[MUL_LAT-1].id[ID_W-1:0];
  assign rsp_data_o  = mul_result_i;
  assign unused_id   = tags[MUL_LAT-1].id;

  rr_arbiter #(
    .N (N_REQ),
    .W (ID_W)
  ) u_arb (
    .req (req_valid_i),
    .ptr (arb_ptr),
    .en  (mul_en_o),
    .gnt (gnt),
    .idx (gnt_idx)
  );

`ifdef FMUL_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [ID_W-1:0] rr_ptr;
  assign arb_ptr = rr_ptr;

  // advance past the winner only on an accepted transfer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      if (gnt_idx == ID_W'(N_REQ - 1))
        rr_ptr <= '0;
      else
        rr_ptr <= gnt_idx + ID_W'(1);
    end
  end
`endif

  // operand mux from the granted requester, zero when idle
  always_comb begin
    mul_opa_o = '0;
    mul_opb_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        mul_opa_o = req_opa_i[k*32 +: 32];
        mul_opb_o = req_opb_i[k*32 +: 32];
      end
    end
  end

  // tag pipeline tracks owner of each in-flight multiply
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MUL_LAT; i++)
        tags[i] <= '0;
    end else if (mul_en_o) begin
      tags[0] <= '{valid: xfer, id: TAG_ID_W'(gnt_idx)};
      for (int i = 1; i < MUL_LAT; i++)
        tags[i] <= tags[i-1];
    end
  end

  // busy while any tag stage holds a live operation
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < MUL_LAT; i++)
      busy_o = busy_o | tags[i].valid;
  end

  // rounding mode only changes when the pipe is empty and idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      mul_rmode_o <= RM_RNE;
    else if (!busy_o && !xfer)
      mul_rmode_o <= rmode_i;
  end

endmodule

// File: tb/tb_fmul_share_arb.sv
// Directed bench for fmul_share_arb with a behavioural
// FP32 multiplier pipeline standing in for the real one.
module tb_fmul_share_arb;

  localparam int N   = 4;
  localparam int LAT = 3;

`ifdef FMUL_ARB_FIXED_PRIO_EN
  localparam bit FX = 1'b1;
`else
  localparam bit FX = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  req_valid;
  logic [N*32-1:0] req_opa;
  logic [N*32-1:0] req_opb;
  logic [N-1:0]  req_ready;
  logic [1:0]    rmode;
  logic          mul_en;
  logic [31:0]   mul_opa;
  logic [31:0]   mul_opb;
  logic [1:0]    mul_rmode;
  logic [31:0]   mul_result;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          rsp_ready;
  logic          busy;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] opa_c [N];
  logic [31:0] opb_c [N];
  logic [31:0] exp_c [N];
  logic [31:0] pipe  [LAT];

  always #5 clk = ~clk;

  fmul_share_arb #(
    .N_REQ   (N),
    .MUL_LAT (LAT),
    .ID_W    (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_opa_i    (req_opa),
    .req_opb_i    (req_opb),
    .req_ready_o  (req_ready),
    .rmode_i      (rmode),
    .mul_en_o     (mul_en),
    .mul_opa_o    (mul_opa),
    .mul_opb_o    (mul_opb),
    .mul_rmode_o  (mul_rmode),
    .mul_result_i (mul_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_data_o   (rsp_data),
    .rsp_ready_i  (rsp_ready),
    .busy_o       (busy)
  );

  function automatic logic [31:0] fmul(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [47:0] m;
    logic [9:0]  e;
    logic [22:0] f;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0)
      return {a[31] ^ b[31], 31'd0};
    m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (m[47]) begin
      f = m[46:24];
      e = e + 10'd1;
    end else begin
      f = m[45:23];
    end
    return {a[31] ^ b[31], e[7:0], f};
  endfunction

  // stand-in multiplier: LAT enabled stages
  always @(posedge clk) begin
    if (mul_en) begin
      pipe[0] <= fmul(mul_opa, mul_opb);
      for (int i = 1; i < LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end
  assign mul_result = pipe[LAT-1];

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni    = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    rmode     = 2'b00;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    opa_c = '{32'h3F800000, 32'h3FC00000,
              32'h40000000, 32'h3F000000};
    opb_c = '{32'h40800000, 32'h40000000,
              32'h40400000, 32'h40A00000};
    exp_c = '{32'h40800000, 32'h40400000,
              32'h40C00000, 32'h40200000};
    for (int k = 0; k < N; k++) begin
      req_opa[k*32 +: 32] = opa_c[k];
      req_opb[k*32 +: 32] = opb_c[k];
    end
    rst_ni    = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    rmode     = 2'b00;

    // reset state
    do_reset();
    @(negedge clk); #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_en", 32'(mul_en), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rmode", 32'(mul_rmode), 32'd0);
    chk("idle_opa", mul_opa, 32'd0);

    // single request from requester 2
    @(negedge clk);
    req_valid = 4'b0100; #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    chk("single_opa", mul_opa, 32'h40000000);
    chk("single_opb", mul_opb, 32'h40400000);
    @(negedge clk);
    req_valid = '0; #1;
    chk("single_c1_valid", 32'(rsp_valid), 32'd0);
    chk("single_c1_busy", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("single_c2_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); #1;
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_id", 32'(rsp_id), 32'd2);
    chk("single_data", rsp_data, 32'h40C00000);
    @(negedge clk); #1;
    chk("single_done_valid", 32'(rsp_valid), 32'd0);
    chk("single_done_busy", 32'(busy), 32'd0);

    // all four requesting: round-robin, back-to-back
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req_valid = (c < 8) ? 4'hF : 4'h0; #1;
      if (c < 8)
        chk("rr_gnt", 32'(req_ready),
            FX ? 32'd1 : 32'd1 << (c % 4));
      else
        chk("rr_gnt_idle", 32'(req_ready), 32'd0);
      if (c >= 3 && c < 11) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rr_rsp_id", 32'(rsp_id),
            FX ? 32'd0 : 32'((c - 3) % 4));
        chk("rr_rsp_data", rsp_data,
            FX ? exp_c[0] : exp_c[(c - 3) % 4]);
      end else begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'd0);
      end
    end

    // backpressure for 5 cycles with a valid response
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 4'hF;
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      rsp_ready = 1'b0; #1;
      chk("stall_mul_en", 32'(mul_en), 32'd0);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_id", 32'(rsp_id), 32'd0);
      chk("stall_data", rsp_data, exp_c[0]);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = '0; #1;
    chk("rel_mul_en", 32'(mul_en), 32'd1);
    chk("rel_id0", 32'(rsp_id), 32'd0);
    @(negedge clk); #1;
    chk("rel_valid1", 32'(rsp_valid), 32'd1);
    chk("rel_id1", 32'(rsp_id), FX ? 32'd0 : 32'd1);
    chk("rel_data1", rsp_data, FX ? exp_c[0] : exp_c[1]);
    @(negedge clk); #1;
    chk("rel_valid2", 32'(rsp_valid), 32'd1);
    chk("rel_id2", 32'(rsp_id), FX ? 32'd0 : 32'd2);
    chk("rel_data2", rsp_data, FX ? exp_c[0] : exp_c[2]);
    @(negedge clk); #1;
    chk("rel_drained", 32'(rsp_valid), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);

    // rounding mode change with two ops in flight
    do_reset();
    @(negedge clk);
    req_valid = 4'b0011; #1;
    chk("rm_gnt0", 32'(req_ready), 32'd1);
    @(negedge clk);
    rmode = 2'b01; #1;
    chk("rm_gnt1", 32'(req_ready), FX ? 32'd1 : 32'd2);
    @(negedge clk);
    req_valid = '0; #1;
    chk("rm_hold_c2", 32'(mul_rmode), 32'd0);
    chk("rm_busy_c2", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("rm_rsp0_valid", 32'(rsp_valid), 32'd1);
    chk("rm_rsp0_id", 32'(rsp_id), 32'd0);
    chk("rm_hold_c3", 32'(mul_rmode), 32'd0);
    @(negedge clk); #1;
    chk("rm_rsp1_id", 32'(rsp_id), FX ? 32'd0 : 32'd1);
    chk("rm_hold_c4", 32'(mul_rmode), 32'd0);
    @(negedge clk); #1;
    chk("rm_idle_busy", 32'(busy), 32'd0);
    chk("rm_hold_c5", 32'(mul_rmode), 32'd0);
    @(negedge clk); #1;
    chk("rm_loaded", 32'(mul_rmode), 32'd1);

    // reset asserted with three ops in flight
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 4'hF;
    end
    @(negedge clk);
    req_valid = '0; #1;
    chk("mid_pre_valid", 32'(rsp_valid), 32'd1);
    rst_ni = 1'b0; #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("mid_no_stale", 32'(rsp_valid), 32'd0);
      chk("mid_no_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    req_valid = 4'hF; #1;
    chk("mid_ptr_zero", 32'(req_ready), 32'd1);

    // requesters 1 and 3 continuously valid
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_valid = 4'b1010; #1;
      chk("pair_gnt", 32'(req_ready),
          (FX || c % 2 == 0) ? 32'h2 : 32'h8);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
